// File: rtl/arbiter_types.sv
// -----------------------------------------------------------------------------
// arbiter_types
//   Shared types and helpers for the cpu_mem_arbiter codebase slice.
//   - arb_state_t : arbitration FSM states (IDLE, I_BUSY, D_BUSY)
//   - arb_src_t   : source of the last completed transaction (round-robin key)
//   - grant_dmem  : round-robin grant decision for the data port
// -----------------------------------------------------------------------------
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } arb_src_t;

  // The data port wins when it is the only requester, or when both request
  // and the previous transaction came from the instruction port.
  function automatic logic grant_dmem(input logic     i_req,
                                      input logic     d_req,
                                      input arb_src_t last_src);
    return d_req && (!i_req || (last_src == SRC_IMEM));
  endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// -----------------------------------------------------------------------------
// arb_perf_counters
//   Saturating performance counters for cpu_mem_arbiter. The whole module only
//   exists when ARB_PERF_CNT_EN is defined.
// Ports
//   clk, rst            clock, asynchronous active-high reset (clears counters)
//   i_grant_imem        pulse: IDLE->I_BUSY transition this cycle
//   i_grant_dmem        pulse: IDLE->D_BUSY transition this cycle
//   i_conflict          IDLE cycle with both ports requesting
//   o_imem_grants       count of instruction grants
//   o_dmem_grants       count of data grants
//   o_conflicts         count of conflicting IDLE cycles
// -----------------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
module arb_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_grant_imem,
  input  logic             i_grant_dmem,
  input  logic             i_conflict,
  output logic [CNT_W-1:0] o_imem_grants,
  output logic [CNT_W-1:0] o_dmem_grants,
  output logic [CNT_W-1:0] o_conflicts
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_imem_grants;
  logic [CNT_W-1:0] r_dmem_grants;
  logic [CNT_W-1:0] r_conflicts;

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imem_grants <= {CNT_W{1'b0}};
      r_dmem_grants <= {CNT_W{1'b0}};
      r_conflicts   <= {CNT_W{1'b0}};
    end else begin
      if (i_grant_imem && (r_imem_grants != CNT_MAX)) begin
        r_imem_grants <= r_imem_grants + CNT_ONE;
      end
      if (i_grant_dmem && (r_dmem_grants != CNT_MAX)) begin
        r_dmem_grants <= r_dmem_grants + CNT_ONE;
      end
      if (i_conflict && (r_conflicts != CNT_MAX)) begin
        r_conflicts <= r_conflicts + CNT_ONE;
      end
    end
  end

  assign o_imem_grants = r_imem_grants;
  assign o_dmem_grants = r_dmem_grants;
  assign o_conflicts   = r_conflicts;

endmodule
`endif

// File: rtl/arb_protocol_chk.sv
// -----------------------------------------------------------------------------
// arb_protocol_chk
//   Protocol assertions for cpu_mem_arbiter; produces no logic.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_dmem_read/write   data port request lines (both at once is illegal)
//   i_imem_resp         instruction completion pulse
//   i_dmem_resp         data completion pulse
// -----------------------------------------------------------------------------
module arb_protocol_chk (
  input  logic clk,
  input  logic rst,
  input  logic i_dmem_read,
  input  logic i_dmem_write,
  input  logic i_imem_resp,
  input  logic i_dmem_resp
);

  // A simultaneous load and store is a core bug; the arbiter treats it as a store.
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (rst)
    !(i_dmem_read && i_dmem_write));

  // Only one requester can be served per backing transaction.
  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    !(i_imem_resp && i_dmem_resp));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//   Responder for the RV32I core's imem (fetch) and dmem (load/store) ports.
//   Serialises both onto one word-wide backing memory port with round-robin
//   arbitration and returns a one-cycle resp pulse to the requester.
//   Optional feature macro: ARB_PERF_CNT_EN (saturating performance counters;
//   when undefined the perf_* outputs are tied to zero).
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   imem_read/imem_address         fetch request (held until imem_resp)
//   imem_rdata/imem_resp           fetch data + completion pulse
//   dmem_read/dmem_write           load/store request (held until dmem_resp)
//   dmem_address/wdata/byte_enable store address, data and lanes
//   dmem_rdata/dmem_resp           load data + completion pulse
//   mem_read/mem_write             registered backing request, held until mem_resp
//   mem_address/wdata/byte_enable  registered backing address/data/lanes
//   mem_rdata/mem_resp             backing read data + completion pulse
//   perf_imem_grants/dmem_grants   transaction grant counters
//   perf_conflicts                 IDLE cycles with both ports requesting
// -----------------------------------------------------------------------------
module cpu_mem_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_read,
  input  logic [ADDR_W-1:0]   imem_address,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_address,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_byte_enable,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic [CNT_W-1:0]    perf_imem_grants,
  output logic [CNT_W-1:0]    perf_dmem_grants,
  output logic [CNT_W-1:0]    perf_conflicts
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_src_t            r_last_src;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]     r_mem_byte_enable;

  logic                w_i_req;
  logic                w_d_req;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_idle;
  logic                w_imem_done;
  logic                w_dmem_done;

  assign w_i_req   = imem_read;
  assign w_d_req   = dmem_read | dmem_write;
  assign w_idle    = (r_state == IDLE);
  assign w_grant_d = grant_dmem(w_i_req, w_d_req, r_last_src);
  assign w_grant_i = w_i_req && !w_grant_d;

  // Arbitration FSM: latches the winning request into the backing-port
  // registers, holds them while busy and clears them on the mem_resp edge.
  // The return to IDLE after every completion gives the mandatory idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_last_src        <= SRC_IMEM;
      r_mem_read        <= 1'b0;
      r_mem_write       <= 1'b0;
      r_mem_address     <= {ADDR_W{1'b0}};
      r_mem_wdata       <= {DATA_W{1'b0}};
      r_mem_byte_enable <= {BE_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            // A simultaneous read+write is illegal and is served as a write.
            r_mem_read        <= dmem_read && !dmem_write;
            r_mem_write       <= dmem_write;
            r_mem_address     <= dmem_address;
            r_mem_wdata       <= dmem_wdata;
            r_mem_byte_enable <= dmem_write ? dmem_byte_enable : {BE_W{1'b0}};
            r_state           <= D_BUSY;
          end else if (w_grant_i) begin
            r_mem_read        <= 1'b1;
            r_mem_write       <= 1'b0;
            r_mem_address     <= imem_address;
            r_mem_wdata       <= {DATA_W{1'b0}};
            r_mem_byte_enable <= {BE_W{1'b0}};
            r_state           <= I_BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            r_last_src        <= (r_state == I_BUSY) ? SRC_IMEM : SRC_DMEM;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_address     <= {ADDR_W{1'b0}};
            r_mem_wdata       <= {DATA_W{1'b0}};
            r_mem_byte_enable <= {BE_W{1'b0}};
            r_state           <= IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state           <= IDLE;
          r_mem_read        <= 1'b0;
          r_mem_write       <= 1'b0;
          r_mem_address     <= {ADDR_W{1'b0}};
          r_mem_wdata       <= {DATA_W{1'b0}};
          r_mem_byte_enable <= {BE_W{1'b0}};
        end
      endcase
    end
  end

  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_byte_enable;

  // Completion is combinational from mem_resp so the requester sees it in the
  // same cycle; mem_resp outside a busy state never reaches the core.
  assign w_imem_done = (r_state == I_BUSY) && mem_resp;
  assign w_dmem_done = (r_state == D_BUSY) && mem_resp;
  assign imem_resp   = w_imem_done;
  assign dmem_resp   = w_dmem_done;
  assign imem_rdata  = w_imem_done ? mem_rdata : {DATA_W{1'b0}};
  assign dmem_rdata  = w_dmem_done ? mem_rdata : {DATA_W{1'b0}};

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_grant_imem  (w_idle && w_grant_i),
    .i_grant_dmem  (w_idle && w_grant_d),
    .i_conflict    (w_idle && w_i_req && w_d_req),
    .o_imem_grants (perf_imem_grants),
    .o_dmem_grants (perf_dmem_grants),
    .o_conflicts   (perf_conflicts)
  );
`else
  assign perf_imem_grants = {CNT_W{1'b0}};
  assign perf_dmem_grants = {CNT_W{1'b0}};
  assign perf_conflicts   = {CNT_W{1'b0}};
`endif

  arb_protocol_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_dmem_read  (dmem_read),
    .i_dmem_write (dmem_write),
    .i_imem_resp  (imem_resp),
    .i_dmem_resp  (dmem_resp)
  );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_mem_arbiter
//   Directed scoreboard bench for cpu_mem_arbiter. Expected backing requests
//   and responses are queued when stimulus is issued; a monitor pops and
//   compares them whenever the DUT presents a request or a resp pulse.
//   Honours ARB_PERF_CNT_EN for the performance-counter expectations.
// -----------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read = 1'b0;
  logic [31:0] imem_address = 32'd0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [31:0] dmem_address = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [3:0]  dmem_byte_enable = 4'd0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp_m;
  logic        mem_resp_inj = 1'b0;
  logic [31:0] perf_imem_grants;
  logic [31:0] perf_dmem_grants;
  logic [31:0] perf_conflicts;

  typedef struct { bit is_d; logic [31:0] data; int cyc; } resp_t;
  typedef struct { bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int cyc; } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    mem_lat = 1;
  logic [31:0] marr [logic [31:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_read        (imem_read),
    .imem_address     (imem_address),
    .imem_rdata       (imem_rdata),
    .imem_resp        (imem_resp),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_byte_enable  (mem_byte_enable),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp_m | mem_resp_inj),
    .perf_imem_grants (perf_imem_grants),
    .perf_dmem_grants (perf_dmem_grants),
    .perf_conflicts   (perf_conflicts)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input bit is_d, input logic [31:0] data, input int c);
    resp_t e;
    e.is_d = is_d; e.data = data; e.cyc = c;
    resp_q.push_back(e);
  endtask

  task automatic push_mreq(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int c);
    mreq_t m;
    m.rd = rd; m.wr = wr; m.addr = addr; m.wdata = wdata; m.be = be; m.cyc = c;
    mreq_q.push_back(m);
  endtask

  // Waits for n_i fetch and n_d data resps, dropping each request after its last resp.
  task automatic wait_done(input int n_i, input int n_d);
    int got_i = 0;
    int got_d = 0;
    int k = 0;
    while ((got_i < n_i || got_d < n_d) && k < 100) begin
      @(negedge clk);
      k++;
      if (imem_resp) begin
        got_i++;
        if (got_i >= n_i) imem_read = 1'b0;
      end
      if (dmem_resp) begin
        got_d++;
        if (got_d >= n_d) begin dmem_read = 1'b0; dmem_write = 1'b0; end
      end
    end
    n_cmp++;
    if (got_i < n_i || got_d < n_d) begin
      n_bad++;
      $display("FAIL resp_timeout: got imem=%0d dmem=%0d expected imem=%0d dmem=%0d", got_i, got_d, n_i, n_d);
      imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
    end
  endtask

  // Conflicting fetch + load issued together while last_src is IMEM.
  task automatic conflict_pair(input logic [31:0] iaddr, input logic [31:0] idata,
                               input logic [31:0] daddr, input logic [31:0] ddata);
    int t;
    mem_lat = 1;
    sync();
    t = cyc;
    push_mreq(1'b1, 1'b0, daddr, 32'd0, 4'b0000, t + 1);
    push_resp(1'b1, ddata, t + 1);
    push_mreq(1'b1, 1'b0, iaddr, 32'd0, 4'b0000, t + 3);
    push_resp(1'b0, idata, t + 3);
    imem_address = iaddr; imem_read = 1'b1;
    dmem_address = daddr; dmem_read = 1'b1;
    wait_done(1, 1);
  endtask

  task automatic dmem_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] rdata, input int lat);
    int t;
    mem_lat = lat;
    sync();
    t = cyc;
    push_mreq(!wr, wr, addr, wdata, wr ? be : 4'b0000, t + 1);
    push_resp(1'b1, rdata, t + lat);
    dmem_address = addr; dmem_wdata = wdata; dmem_byte_enable = be;
    dmem_read = !wr; dmem_write = wr;
    wait_done(0, 1);
    dmem_wdata = 32'd0; dmem_byte_enable = 4'd0;
  endtask

  // Backing memory model: mem_resp arrives mem_lat-1 cycles after the request appears.
  initial begin : mem_model
    int wait_cnt;
    logic [31:0] tmp;
    marr[32'h60]  = 32'h0000_0013;
    marr[32'h64]  = 32'h0010_0093;
    marr[32'h200] = 32'hCAFE_F00D;
    wait_cnt = 0;
    mem_resp_m = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_m = 1'b0;
      mem_rdata = 32'd0;
      if (mem_read || mem_write) begin
        if (wait_cnt == 0) wait_cnt = mem_lat;
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_resp_m = 1'b1;
          if (mem_write) begin
            tmp = marr.exists(mem_address) ? marr[mem_address] : 32'd0;
            for (int b = 0; b < 4; b++) begin
              if (mem_byte_enable[b]) tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
            marr[mem_address] = tmp;
          end else begin
            mem_rdata = marr.exists(mem_address) ? marr[mem_address] : 32'hBAD0_0000;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: checks every resp pulse and backing request against the queues.
  initial begin : monitor
    resp_t e;
    mreq_t m;
    logic prev_req;
    logic p_rd, p_wr;
    logic [31:0] p_addr, p_wdata;
    logic [3:0] p_be;
    prev_req = 1'b0;
    p_rd = 1'b0; p_wr = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_be = 4'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (imem_resp || dmem_resp) begin
          chk("single_resp", {31'd0, imem_resp & dmem_resp}, 32'd0);
          if (resp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: imem_resp=%0b dmem_resp=%0b, expected none (cycle %0d)", imem_resp, dmem_resp, cyc);
          end else begin
            e = resp_q.pop_front();
            chk("resp_port_is_dmem", {31'd0, dmem_resp}, {31'd0, e.is_d});
            chk("resp_rdata", dmem_resp ? dmem_rdata : imem_rdata, e.data);
            if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
          end
        end
        if ((mem_read || mem_write) && !prev_req) begin
          if (mreq_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_mem_req: addr 0x%08h, expected none (cycle %0d)", mem_address, cyc);
          end else begin
            m = mreq_q.pop_front();
            chk("mem_read", {31'd0, mem_read}, {31'd0, m.rd});
            chk("mem_write", {31'd0, mem_write}, {31'd0, m.wr});
            chk("mem_address", mem_address, m.addr);
            chk("mem_wdata", mem_wdata, m.wdata);
            chk("mem_byte_enable", {28'd0, mem_byte_enable}, {28'd0, m.be});
            if (m.cyc >= 0) chk("mem_req_cycle", cyc, m.cyc);
          end
        end else if (mem_read || mem_write) begin
          chk("hold_rw", {30'd0, mem_read, mem_write}, {30'd0, p_rd, p_wr});
          chk("hold_address", mem_address, p_addr);
          chk("hold_wdata", mem_wdata, p_wdata);
          chk("hold_be", {28'd0, mem_byte_enable}, {28'd0, p_be});
        end
        prev_req = mem_read || mem_write;
        p_rd = mem_read; p_wr = mem_write;
        p_addr = mem_address; p_wdata = mem_wdata; p_be = mem_byte_enable;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_byte_enable}, 32'd0);
    chk("rst_resps", {30'd0, imem_resp, dmem_resp}, 32'd0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    chk("rst_perf_conflicts", perf_conflicts, 32'd0);
    sync();
    rst = 1'b0;

    // 1: fetch 0x60, memory latency 3.
    mem_lat = 3;
    sync();
    t = cyc;
    push_mreq(1'b1, 1'b0, 32'h60, 32'd0, 4'b0000, t + 1);
    push_resp(1'b0, 32'h0000_0013, t + 3);
    imem_address = 32'h60; imem_read = 1'b1;
    wait_done(1, 0);

    // 3: fetch and load together with last_src=IMEM -> load first.
    conflict_pair(32'h64, 32'h0010_0093, 32'h200, 32'hCAFE_F00D);

    // 2: full-word store; 4: single-lane store; then read back the merged word.
    dmem_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'd0, 2);
    dmem_txn(1'b1, 32'h100, 32'hAB00_0000, 4'b1000, 32'd0, 1);
    dmem_txn(1'b0, 32'h100, 32'd0, 4'b0000, 32'hABAD_BEEF, 2);

    // Fetch held across the mandatory IDLE cycle is served twice.
    mem_lat = 1;
    sync();
    t = cyc;
    push_mreq(1'b1, 1'b0, 32'h60, 32'd0, 4'b0000, t + 1);
    push_resp(1'b0, 32'h0000_0013, t + 1);
    push_mreq(1'b1, 1'b0, 32'h60, 32'd0, 4'b0000, t + 3);
    push_resp(1'b0, 32'h0000_0013, t + 3);
    imem_address = 32'h60; imem_read = 1'b1;
    wait_done(2, 0);

    // Load dropped while busy still completes.
    mem_lat = 3;
    sync();
    t = cyc;
    push_mreq(1'b1, 1'b0, 32'h200, 32'd0, 4'b0000, t + 1);
    push_resp(1'b1, 32'hCAFE_F00D, t + 3);
    dmem_address = 32'h200; dmem_read = 1'b1;
    sync();
    dmem_read = 1'b0;
    wait_done(0, 1);

    // 6: counters from a clean reset over three conflicting pairs.
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    conflict_pair(32'h60, 32'h0000_0013, 32'h200, 32'hCAFE_F00D);
    conflict_pair(32'h60, 32'h0000_0013, 32'h200, 32'hCAFE_F00D);
    conflict_pair(32'h60, 32'h0000_0013, 32'h200, 32'hCAFE_F00D);
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflicts", perf_conflicts, 32'd3);
    chk("perf_imem_grants", perf_imem_grants, 32'd3);
    chk("perf_dmem_grants", perf_dmem_grants, 32'd3);
`else
    chk("perf_conflicts", perf_conflicts, 32'd0);
    chk("perf_imem_grants", perf_imem_grants, 32'd0);
    chk("perf_dmem_grants", perf_dmem_grants, 32'd0);
`endif

    // 5: reset while a store is outstanding, then a stray mem_resp in IDLE.
    mem_lat = 5;
    sync();
    t = cyc;
    push_mreq(1'b0, 1'b1, 32'h300, 32'h1122_3344, 4'b1111, t + 1);
    dmem_address = 32'h300; dmem_wdata = 32'h1122_3344; dmem_byte_enable = 4'b1111;
    dmem_write = 1'b1;
    sync();
    sync();
    chk("t5_busy_write", {31'd0, mem_write}, 32'd1);
    #1;
    rst = 1'b1;
    dmem_write = 1'b0; dmem_address = 32'd0; dmem_wdata = 32'd0; dmem_byte_enable = 4'd0;
    #1;
    chk("t5_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("t5_rst_dmem_resp", {31'd0, dmem_resp}, 32'd0);
    chk("t5_rst_mem_address", mem_address, 32'd0);
    sync();
    sync();
    rst = 1'b0;
    sync();
    mem_resp_inj = 1'b1;
    @(negedge clk);
    chk("t5_idle_resps", {30'd0, imem_resp, dmem_resp}, 32'd0);
    sync();
    mem_resp_inj = 1'b0;
    @(negedge clk);
    chk("t5_idle_mem_req", {30'd0, mem_read, mem_write}, 32'd0);

    // Normal service after the abandoned transaction.
    mem_lat = 1;
    sync();
    t = cyc;
    push_mreq(1'b1, 1'b0, 32'h60, 32'd0, 4'b0000, t + 1);
    push_resp(1'b0, 32'h0000_0013, t + 1);
    imem_address = 32'h60; imem_read = 1'b1;
    wait_done(1, 0);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", resp_q.size(), 32'd0);
    chk("mreq_queue_empty", mreq_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
